prog_loader: RTL and testbench

Boot-time program loader for the 8-bit stack CPU. It receives a program as a byte stream over a valid/ready interface and writes 12-bit instructions into the instruction memory write port. It holds the CPU in reset until a complete, checksum-verified program has been written. It sits between the host/debug link and the instruction memory, and drives the CPU's reset input.

---
 rtl/prog_loader_if.sv | 25 ++
 rtl/prog_loader.sv | 144 ++++++++++++++
 tb/tb_prog_loader.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Host byte stream and instruction-memory write port of the program loader.
// The loader is the slave: it consumes host bytes and drives the write port.
interface prog_loader_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 12
) ();

  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               im_we;
  logic [ADDR_W-1:0]  im_addr;
  logic [INSTR_W-1:0] im_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, im_we, im_addr, im_wdata
  );

endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader for the 8-bit stack CPU.
// Parses {N, N x {hi, lo}, C} from the host byte stream, writes each
// {opcode, operand} into instruction memory and keeps the CPU in reset until
// a complete program with a zero byte-sum has been written.
module prog_loader #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  prog_loader_if.slave      bus,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int CNT_W = ADDR_W + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_HI   = 3'd2;
  localparam logic [2:0] S_LO   = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;

  // Highest legal opcode (SUB); anything above it in a hi byte aborts the load.
  localparam logic [7:0] MAX_OPCODE = 8'h07;

  logic [2:0]        state;
  logic [CNT_W-1:0]  remaining;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        sum;
  logic [3:0]        opcode;
  logic              accepting;
  logic              take;
  logic [7:0]        sum_next;

  // The loader listens to the host only while parsing a stream.
  assign accepting = (state == S_HDR) || (state == S_HI) ||
                     (state == S_LO)  || (state == S_CSUM);
  assign take      = accepting && bus.in_valid;
  assign sum_next  = sum + bus.in_data;

  assign bus.in_ready = accepting;
  assign busy         = accepting;

  // Stream parser, memory write port and status flags share one register stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      remaining    <= '0;
      addr         <= '0;
      sum          <= '0;
      opcode       <= '0;
      bus.im_we    <= 1'b0;
      bus.im_addr  <= '0;
      bus.im_wdata <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the pre-edge register values; the default below turns im_we into a
      // one-cycle pulse that only the LO branch re-arms.
      bus.im_we <= 1'b0;

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state     <= S_HDR;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            cpu_reset <= 1'b1;
          end
        end

        S_HDR: begin
          if (take) begin
            // A header of zero stands for a full 256-instruction program.
            remaining <= (bus.in_data == 8'h00) ? CNT_W'(256) : CNT_W'(bus.in_data);
            addr      <= '0;
            sum       <= bus.in_data;
            state     <= S_HI;
          end
        end

        S_HI: begin
          if (take) begin
            sum <= sum_next;
            if (bus.in_data > MAX_OPCODE) begin
              state    <= S_ERR;
              err      <= 1'b1;
              err_code <= ERR_ILLEGAL;
            end else begin
              opcode <= bus.in_data[3:0];
              state  <= S_LO;
            end
          end
        end

        S_LO: begin
          if (take) begin
            sum          <= sum_next;
            bus.im_we    <= 1'b1;
            bus.im_addr  <= addr;
            bus.im_wdata <= INSTR_W'({opcode, bus.in_data});
            // addr wraps to 0 after the 256th write, which is always the last.
            addr         <= addr + ADDR_W'(1);
            remaining    <= remaining - CNT_W'(1);
            state        <= (remaining == CNT_W'(1)) ? S_CSUM : S_HI;
          end
        end

        S_CSUM: begin
          if (take) begin
            sum <= sum_next;
            if (sum_next == 8'h00) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state    <= S_ERR;
              err      <= 1'b1;
              err_code <= ERR_CSUM;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: the stimulus side pushes the writes a
// stream should produce into a scoreboard queue; a negedge monitor pops and
// compares each im_we pulse. Load outcomes come from a stream-level model.
module tb_prog_loader;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [7:0]  addr;
    logic [11:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       cpu_reset;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  prog_loader_if #(.ADDR_W(8), .INSTR_W(12)) bus ();

  prog_loader #(.ADDR_W(8), .INSTR_W(12)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  int  n_cmp = 0;
  int  n_bad = 0;
  wr_t exp_q[$];
  wr_t m_writes[$];
  int  m_outcome;          // 0 = done, 1 = illegal opcode, 2 = checksum error
  bit  start_pulse_pending = 1'b0;
  bit  gap_phase = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.im_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_im_we", bus.im_we, 1'b0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("im_addr", bus.im_addr, w.addr);
        check("im_wdata", bus.im_wdata, w.data);
      end
    end
  end

  // Reference model: interpret a stream at the level of its format rules.
  task automatic run_model(input bq_t s);
    int n;
    logic [7:0] total;
    m_writes.delete();
    n = (s[0] == 8'h00) ? 256 : int'(s[0]);
    for (int i = 0; i < n; i++) begin
      wr_t w;
      if (s[1 + 2*i] > 8'h07) begin
        m_outcome = 1;
        return;
      end
      w.addr = i[7:0];
      w.data = {s[1 + 2*i][3:0], s[2 + 2*i]};
      m_writes.push_back(w);
    end
    total = 8'h00;
    for (int j = 0; j <= 2*n + 1; j++) total = total + s[j];
    m_outcome = (total == 8'h00) ? 0 : 2;
  endtask

  // Build a random stream: mode 0 good, 1 bad checksum, 2 illegal hi at pair bad_at.
  function automatic bq_t make_stream(input int n, input int mode, input int bad_at);
    bq_t s;
    logic [7:0] total, b;
    int hdr;
    hdr = n % 256;
    s.push_back(hdr[7:0]);
    total = hdr[7:0];
    for (int i = 0; i < n; i++) begin
      if (mode == 2 && i == bad_at) begin
        b = 8'($urandom_range(8, 255));
        s.push_back(b);
        return s;
      end
      b = 8'($urandom_range(0, 7));
      s.push_back(b);
      total = total + b;
      b = 8'($urandom);
      s.push_back(b);
      total = total + b;
    end
    b = 8'h00 - total;
    if (mode == 1) b = b + 8'($urandom_range(1, 255));
    s.push_back(b);
    return s;
  endfunction

  // Present one byte until the loader takes it; gappy mode idles every other cycle.
  task automatic send_byte(input logic [7:0] b, input bit gappy, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      start = start_pulse_pending;
      start_pulse_pending = 1'b0;
      gap_phase = ~gap_phase;
      if (gappy && gap_phase) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        if (bus.in_ready === 1'b1) begin
          ok = 1'b1;
          break;
        end
      end
    end
    if (!ok) check("accept_timeout", bus.in_ready, 1'b1);
  endtask

  // Stream the first n_send bytes; a start pulse rides along with byte start_at.
  task automatic send_stream(input bq_t s, input bit gappy, input int n_send, input int start_at);
    bit ok;
    int n;
    run_model(s);
    n = (s[0] == 8'h00) ? 256 : int'(s[0]);
    for (int j = 0; j < n_send; j++) begin
      if (j == start_at) start_pulse_pending = 1'b1;
      send_byte(s[j], gappy, ok);
      if (!ok) break;
      if (j >= 2 && j <= 2*n && (j % 2) == 0 && (j - 2)/2 < m_writes.size())
        exp_q.push_back(m_writes[(j - 2)/2]);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("in_ready_after_start", bus.in_ready, 1'b1);
    check("busy_after_start", busy, 1'b1);
    check("done_cleared", done, 1'b0);
    check("err_cleared", err, 1'b0);
    check("err_code_cleared", err_code, 2'b00);
    check("cpu_reset_held", cpu_reset, 1'b1);
  endtask

  // Sampled on the negedge right after the edge that took the final byte.
  task automatic check_outcome();
    logic [31:0] ec;
    ec = (m_outcome == 1) ? 1 : (m_outcome == 2) ? 2 : 0;
    check("done", done, m_outcome == 0);
    check("err", err, m_outcome != 0);
    check("err_code", err_code, ec);
    check("cpu_reset", cpu_reset, m_outcome != 0);
    check("in_ready_end", bus.in_ready, 1'b0);
    check("busy_end", busy, 1'b0);
    check("writes_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_im_we", bus.im_we, 1'b0);
    check("rst_im_addr", bus.im_addr, 8'h00);
    check("rst_im_wdata", bus.im_wdata, 12'h000);
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_err_code", err_code, 2'b00);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bq_t good, bad_sum, illegal, s;
    bit ok;

    reset = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values();

    // Out of reset the loader stays in IDLE and ignores host bytes.
    reset = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h03;
    repeat (20) @(negedge clk);
    bus.in_valid = 1'b0;
    check("idle_in_ready", bus.in_ready, 1'b0);
    check("idle_cpu_reset", cpu_reset, 1'b1);
    check("idle_busy", busy, 1'b0);

    good    = '{8'h03, 8'h00, 8'h05, 8'h00, 8'h0A, 8'h06, 8'h00, 8'hE8};
    bad_sum = '{8'h03, 8'h00, 8'h05, 8'h00, 8'h0A, 8'h06, 8'h00, 8'hE9};
    illegal = '{8'h01, 8'h09};

    // Directed good load: expected writes 0:005, 1:00A, 2:600.
    do_start();
    send_stream(good, 1'b0, good.size(), -1);
    check_outcome();

    // Illegal opcode aborts with no write, then a clean restart.
    do_start();
    send_stream(illegal, 1'b0, illegal.size(), -1);
    check_outcome();
    do_start();
    send_stream(good, 1'b0, good.size(), -1);
    check_outcome();

    // Checksum mismatch: writes still land, outcome is an error.
    do_start();
    send_stream(bad_sum, 1'b0, bad_sum.size(), -1);
    check_outcome();

    // Backpressure with a start pulse in the middle of the load.
    do_start();
    send_stream(good, 1'b1, good.size(), 3);
    check_outcome();

    // Randomized loads of every outcome kind.
    for (int k = 0; k < 12; k++) begin
      int n, mode;
      n    = $urandom_range(1, 20);
      mode = $urandom_range(0, 2);
      s = make_stream(n, mode, $urandom_range(0, n - 1));
      do_start();
      send_stream(s, 1'($urandom_range(0, 1)), s.size(), -1);
      check_outcome();
    end

    // Full depth: header 0 means 256 instructions, addresses 0..255.
    do_start();
    s = make_stream(256, 0, 0);
    send_stream(s, 1'b0, s.size(), -1);
    check_outcome();

    // Same load again, reset while the 11th write is on the bus.
    do_start();
    s = make_stream(256, 0, 0);
    send_stream(s, 1'b0, 21, -1);
    send_byte(s[21], 1'b0, ok);
    send_byte(s[22], 1'b0, ok);
    @(posedge clk);
    #1;
    check("im_we_before_reset", bus.im_we, 1'b1);
    reset = 1'b1;
    #1;
    check_reset_values();
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values();
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("post_reset_in_ready", bus.in_ready, 1'b0);
    check("post_reset_cpu_reset", cpu_reset, 1'b1);
    check("post_reset_queue", exp_q.size(), 0);

    // Recovery after the interrupted load.
    do_start();
    send_stream(good, 1'b0, good.size(), -1);
    check_outcome();

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
